// File: rtl/axi4lite_lsu_master_if.sv
// AXI4-Lite master-side bundle used by the LSU bridge.
// The maxi_* names keep it wire-compatible with the pass-through stage's saxi_* ports.
interface axi4lite_lsu_master_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic [ADDR_WIDTH-1:0] maxi_araddr;
   logic [2:0]            maxi_arprot;
   logic                  maxi_arvalid;
   logic                  maxi_arready;
   logic [DATA_WIDTH-1:0] maxi_rdata;
   logic [1:0]            maxi_rresp;
   logic                  maxi_rvalid;
   logic                  maxi_rready;
   logic [ADDR_WIDTH-1:0] maxi_awaddr;
   logic [2:0]            maxi_awprot;
   logic                  maxi_awvalid;
   logic                  maxi_awready;
   logic [DATA_WIDTH-1:0] maxi_wdata;
   logic [STRB_WIDTH-1:0] maxi_wstrb;
   logic                  maxi_wvalid;
   logic                  maxi_wready;
   logic [1:0]            maxi_bresp;
   logic                  maxi_bvalid;
   logic                  maxi_bready;

   modport master (
      output maxi_araddr, maxi_arprot, maxi_arvalid, maxi_rready,
             maxi_awaddr, maxi_awprot, maxi_awvalid,
             maxi_wdata, maxi_wstrb, maxi_wvalid, maxi_bready,
      input  maxi_arready, maxi_rdata, maxi_rresp, maxi_rvalid,
             maxi_awready, maxi_wready, maxi_bresp, maxi_bvalid
   );

   modport slave (
      input  maxi_araddr, maxi_arprot, maxi_arvalid, maxi_rready,
             maxi_awaddr, maxi_awprot, maxi_awvalid,
             maxi_wdata, maxi_wstrb, maxi_wvalid, maxi_bready,
      output maxi_arready, maxi_rdata, maxi_rresp, maxi_rvalid,
             maxi_awready, maxi_wready, maxi_bresp, maxi_bvalid
   );
endinterface

// File: rtl/axi4lite_lsu_master.sv
// Single-outstanding load/store bridge from the core pipeline to AXI4-Lite.
// Handles lane steering, strobes, misalignment and load extension.
module axi4lite_lsu_master #(
   parameter int         ADDR_WIDTH     = 64,
   parameter int         AXI_DATA_WIDTH = 64,
   parameter int         STRB_WIDTH     = AXI_DATA_WIDTH / 8,
   parameter logic [2:0] AXI_PROT       = 3'b000
) (
   input  logic                  axi_clk,
   input  logic                  axi_rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [63:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [63:0]           rsp_rdata,
   output logic                  rsp_err,
   axi4lite_lsu_master_if.master maxi
);
   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [2:0]            off_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [63:0]           wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic                  aw_done_q, w_done_q;
   logic                  err_q;
   logic [63:0]           rdata_q;

   logic                  accept, misaligned;
   logic [STRB_WIDTH-1:0] strb_base;
   logic [63:0]           rd_shifted, rd_ext;

   assign accept = req_valid && (state_q == IDLE);

   always_comb begin
      misaligned = 1'b0;
      strb_base  = 8'h01;
      case (req_size)
         2'd0: begin misaligned = 1'b0;                strb_base = 8'h01; end
         2'd1: begin misaligned = req_addr[0];         strb_base = 8'h03; end
         2'd2: begin misaligned = |req_addr[1:0];      strb_base = 8'h0F; end
         default: begin misaligned = |req_addr[2:0];   strb_base = 8'hFF; end
      endcase
   end

   always_comb begin
      rd_shifted = maxi.maxi_rdata >> {off_q, 3'b000};
      rd_ext     = rd_shifted;
      case (size_q)
         2'd0: rd_ext = uns_q ? {56'd0, rd_shifted[7:0]}  : {{56{rd_shifted[7]}},  rd_shifted[7:0]};
         2'd1: rd_ext = uns_q ? {48'd0, rd_shifted[15:0]} : {{48{rd_shifted[15]}}, rd_shifted[15:0]};
         2'd2: rd_ext = uns_q ? {32'd0, rd_shifted[31:0]} : {{32{rd_shifted[31]}}, rd_shifted[31:0]};
         default: rd_ext = rd_shifted;
      endcase
   end

   always_ff @(posedge axi_clk) begin
      if (axi_rst) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = misaligned ? RSP : (req_we ? WR_REQ : RD_ADDR);
         RD_ADDR: if (maxi.maxi_arready) state_d = RD_DATA;
         RD_DATA: if (maxi.maxi_rvalid) state_d = RSP;
         // Either channel may finish first; advance once both have handshaken.
         WR_REQ:  if ((aw_done_q || maxi.maxi_awready) && (w_done_q || maxi.maxi_wready))
                     state_d = WR_RESP;
         WR_RESP: if (maxi.maxi_bvalid) state_d = RSP;
         RSP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         addr_q    <= '0;
         off_q     <= '0;
         size_q    <= '0;
         uns_q     <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         if (accept) begin
            addr_q    <= {req_addr[ADDR_WIDTH-1:3], 3'b000};
            off_q     <= req_addr[2:0];
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            wdata_q   <= req_wdata << {req_addr[2:0], 3'b000};
            wstrb_q   <= strb_base << req_addr[2:0];
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= misaligned;
            rdata_q   <= '0;
         end
         if (state_q == WR_REQ) begin
            if (maxi.maxi_awready) aw_done_q <= 1'b1;
            if (maxi.maxi_wready)  w_done_q  <= 1'b1;
         end
         if (state_q == RD_DATA && maxi.maxi_rvalid) begin
            err_q   <= (maxi.maxi_rresp != 2'b00);
            rdata_q <= (maxi.maxi_rresp != 2'b00) ? '0 : rd_ext;
         end
         if (state_q == WR_RESP && maxi.maxi_bvalid) begin
            err_q   <= (maxi.maxi_bresp != 2'b00);
            rdata_q <= '0;
         end
      end
   end

   always_comb begin
      req_ready         = (state_q == IDLE);
      maxi.maxi_arvalid = (state_q == RD_ADDR);
      maxi.maxi_rready  = (state_q == RD_DATA);
      maxi.maxi_awvalid = (state_q == WR_REQ) && !aw_done_q;
      maxi.maxi_wvalid  = (state_q == WR_REQ) && !w_done_q;
      maxi.maxi_bready  = (state_q == WR_RESP);
      rsp_valid         = (state_q == RSP);
      rsp_err           = (state_q == RSP) && err_q;
      rsp_rdata         = (state_q == RSP) ? rdata_q : '0;
   end

   assign maxi.maxi_araddr = addr_q;
   assign maxi.maxi_awaddr = addr_q;
   assign maxi.maxi_arprot = AXI_PROT;
   assign maxi.maxi_awprot = AXI_PROT;
   assign maxi.maxi_wdata  = wdata_q;
   assign maxi.maxi_wstrb  = wstrb_q;
endmodule

// File: doc/axi4lite_lsu_master.md
Name: axi4lite_lsu_master

Overview:
- Core-side load/store unit bridge; converts single load/store requests from the RV64 pipeline into AXI4-Lite master transactions.
- Its maxi_* port set connects directly to the saxi_* port set of the core's AXI4-Lite pass-through stage.
- One outstanding transaction at a time.
- Handles byte-lane steering, write strobes, misalignment detection and load sign/zero extension.

Parameters:
ADDR_WIDTH, 64, address width of request and AXI address channels
AXI_DATA_WIDTH, 64, data bus width; only 64 is supported
STRB_WIDTH, 8, AXI_DATA_WIDTH/8 write-strobe width
AXI_PROT, 3'b000, constant driven on maxi_arprot/maxi_awprot

Ports:
axi_clk  in  1  clock; all logic on rising edge
axi_rst  in  1  reset, synchronous, active-high
req_valid  in  1  core request valid
req_ready  out  1  block can accept request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  0=byte 1=half 2=word 3=double
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  64  store data, right-justified
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  64  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned access or non-OKAY AXI response
maxi_araddr / maxi_arprot / maxi_arvalid  out  ADDR_WIDTH/3/1  read address channel
maxi_arready  in  1
maxi_rdata / maxi_rresp / maxi_rvalid  in  64/2/1  read data channel
maxi_rready  out  1
maxi_awaddr / maxi_awprot / maxi_awvalid  out  ADDR_WIDTH/3/1  write address channel
maxi_awready  in  1
maxi_wdata / maxi_wstrb / maxi_wvalid  out  64/8/1  write data channel
maxi_wready  in  1
maxi_bready  out  1  write response channel
maxi_bresp / maxi_bvalid  in  2/1

Behaviour:
Reset: axi_rst high at an edge forces state IDLE. All of these go to 0: valid/ready outputs, addr, wdata, wstrb, rsp_*.
- Reset mid-transaction aborts with no rsp_valid.
- Late slave responses after reset are ignored.
FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP. req_ready = (state==IDLE).
Accept at edge N (req_valid && req_ready). Request fields are latched.
Alignment: legal when size0 any; size1 addr[0]==0; size2 addr[1:0]==0; size3 addr[2:0]==0.
- Misaligned: go to RSP with rsp_err=1 and no AXI traffic. rsp_valid is high in cycle N+1.
Address driven on AXI = {req_addr[ADDR_WIDTH-1:3],3'b000}. off = req_addr[2:0].
Write lanes:
- maxi_wdata = req_wdata << (8*off).
- maxi_wstrb = (8'h01, 8'h03, 8'h0F, 8'hFF per size) << off.
Load path:
- Extract maxi_rdata >> (8*off).
- Take the low 8/16/32/64 bits.
- Sign- or zero-extend per req_unsigned; size3 is passed unmodified.
Read sequence:
- RD_ADDR: arvalid=1 from N+1, held stable until the arready handshake. Then go to RD_DATA; arvalid drops the next cycle.
- RD_DATA: rready=1. On rvalid, capture data/resp, drop rready, go to RSP.
Write sequence:
- WR_REQ: awvalid and wvalid both go high from N+1.
- Each channel deasserts independently after its own handshake; both may complete in the same cycle or in either order.
- When both are done, go to WR_RESP: bready=1. On bvalid, go to RSP.
RSP: rsp_valid=1 for exactly one cycle, then IDLE.
- rsp_err=1 if the resp field != 2'b00.
- rsp_rdata=0 on error or store.
- No backpressure on rsp; the core must consume the pulse.
Minimum latency with zero-wait slave:
- Load: accept N, arvalid N+1, rvalid N+2, rsp_valid N+3.
- Store: rsp_valid N+3.
Illegal activity: rvalid/bvalid outside their wait states is ignored (ready low). No AXI handshake is ever issued from IDLE/RSP.

Test Plan:
1. Load byte, signed: addr 0x1003, rdata 0x00000000_80FF7700 -> araddr 0x1000, rsp_rdata 0xFFFFFFFF_FFFFFF80, rsp_err 0, rsp_valid at N+3.
2. Store half: addr 0x2006, wdata 0xABCD -> awaddr 0x2000, wdata 0xABCD0000_00000000, wstrb 0xC0. With awready 2 cycles before wready, both deassert independently and exactly one rsp_valid is produced.
3. Misaligned word load at addr 0x3002 -> rsp_valid at N+1, rsp_err 1, arvalid never asserted.
4. Unsigned word load addr 0x4004, rdata 0x89ABCDEF_00000000, rresp 2'b10 -> rsp_err 1, rsp_rdata 0. Repeat with rresp 00 -> rsp_rdata 0x00000000_89ABCDEF.
5. Slave holds arready low 5 cycles -> araddr/arvalid stay stable throughout and req_ready stays 0.
6. Assert axi_rst during WR_RESP -> next cycle all valids/readies 0, state IDLE, req_ready 1 after reset release; a subsequent bvalid produces no rsp_valid.
